// File: rtl/shift_rotate_pkg.sv
// rtl/shift_rotate_pkg.sv - shared width, opcode constants and opcode enum for the shift/rotate unit
package shift_rotate_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SAR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;

  typedef enum logic [2:0] {
    OPC_SHL  = 3'd0,
    OPC_SHR  = 3'd1,
    OPC_SAR  = 3'd2,
    OPC_ROL  = 3'd3,
    OPC_ROR  = 3'd4,
    OPC_SWAP = 3'd5,
    OPC_RSV6 = 3'd6,
    OPC_RSV7 = 3'd7
  } opcode_e;

endpackage

// File: rtl/shift_rotate_comb.sv
// rtl/shift_rotate_comb.sv - combinational single-step shift/rotate decode with carry and zero
module shift_rotate_comb
  import shift_rotate_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [2:0]       opcode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  opcode_e op;
  assign op = opcode_e'(opcode_i);

  always_comb begin
    result_o = a_i;
    carry_o  = 1'b0;
    case (op)
      OPC_SHL: begin
        result_o = {a_i[6:0], 1'b0};
        carry_o  = a_i[7];
      end
      OPC_SHR: begin
        result_o = {1'b0, a_i[7:1]};
        carry_o  = a_i[0];
      end
      OPC_SAR: begin
        result_o = {a_i[7], a_i[7:1]};
        carry_o  = a_i[0];
      end
      OPC_ROL: begin
        result_o = {a_i[6:0], a_i[7]};
        carry_o  = a_i[7];
      end
      OPC_ROR: begin
        result_o = {a_i[0], a_i[7:1]};
        carry_o  = a_i[0];
      end
      OPC_SWAP: begin
        result_o = {a_i[3:0], a_i[7:4]};
        carry_o  = 1'b0;
      end
      // Reserved opcodes pass the operand through so the output is never X.
      default: begin
        result_o = a_i;
        carry_o  = 1'b0;
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/shift_rotate_core.sv
// rtl/shift_rotate_core.sv - registered shift/rotate unit with one-cycle latency and valid bit
module shift_rotate_core
  import shift_rotate_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             zero_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;

  shift_rotate_comb u_comb (
    .a_i      (a),
    .opcode_i (opcode),
    .result_o (result_d),
    .carry_o  (carry_d),
    .zero_o   (zero_d)
  );

  // Data registers only load on valid so the last result holds through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_shift_rotate_core.sv
// tb/tb_shift_rotate_core.sv - scoreboard bench for shift_rotate_core
module tb_shift_rotate_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [2:0] opcode;
  logic       out_valid;
  logic [7:0] result;
  logic       carry;
  logic       zero;

  shift_rotate_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .opcode    (opcode),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] r;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  logic [7:0] mdl_r;
  logic       mdl_c;
  logic       mdl_z;

  function automatic void model(input logic [7:0] x, input logic [2:0] op,
                                output logic [7:0] r, output logic c);
    case (op)
      3'd0: begin r = x << 1;                              c = x[7]; end
      3'd1: begin r = x >> 1;                              c = x[0]; end
      3'd2: begin r = 8'($signed(x) >>> 1);                c = x[0]; end
      3'd3: begin r = 8'(x << 1) | 8'(x >> 7);             c = x[7]; end
      3'd4: begin r = 8'(x >> 1) | 8'(x << 7);             c = x[0]; end
      3'd5: begin r = 8'(x << 4) | 8'(x >> 4);             c = 1'b0; end
      default: begin r = x;                                c = 1'b0; end
    endcase
  endfunction

  task automatic step(input logic v, input logic [7:0] av, input logic [2:0] op);
    exp_t e;
    logic [7:0] r;
    logic       c;
    @(negedge clk);
    in_valid = v;
    a        = av;
    opcode   = op;
    if (v) begin
      model(av, op, r, c);
      mdl_r = r;
      mdl_c = c;
      mdl_z = (r == 8'h00);
    end
    e = '{v: v, r: mdl_r, c: mdl_c, z: mdl_z};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; opcode = 3'd0;
    #2;
    n_vec++;
    if ({out_valid, result, carry, zero} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_initial: got v=%b r=%h c=%b z=%b want all 0", out_valid, result, carry, zero);
    end
    mdl_r = 8'h00; mdl_c = 1'b0; mdl_z = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 8'hB5, 3'd3);
    e = sb.pop_front();
    n_vec++;
    if ({out_valid, result, carry, zero} !== {e.v, e.r, e.c, e.z}) begin
      n_err++;
      $display("FAIL reset_first_op: got v=%b r=%h c=%b z=%b want v=%b r=%h c=%b z=%b",
               out_valid, result, carry, zero, e.v, e.r, e.c, e.z);
    end
    // Mid-stream asynchronous reset, away from any clock edge.
    in_valid = 1'b1;
    #2; rst_n = 1'b0; #1;
    n_vec++;
    if ({out_valid, result, carry, zero} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b r=%h c=%b z=%b want all 0", out_valid, result, carry, zero);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, result, carry, zero} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_held: got v=%b r=%h c=%b z=%b want all 0", out_valid, result, carry, zero);
    end
    mdl_r = 8'h00; mdl_c = 1'b0; mdl_z = 1'b0;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [7:0] want_r [6] = '{8'h6A, 8'h5A, 8'hDA, 8'h6B, 8'hDA, 8'h5B};
    logic       want_c [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hB5, 3'(i));
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, zero} !== {1'b1, want_r[i], want_c[i], 1'b0} ||
          {e.r, e.c} !== {want_r[i], want_c[i]}) begin
        n_err++;
        $display("FAIL b2b_op%0d: got v=%b r=%h c=%b z=%b want v=1 r=%h c=%b z=0",
                 i, out_valid, result, carry, zero, want_r[i], want_c[i]);
      end
    end
  endtask

  task automatic test_reserved;
    exp_t e;
    for (int i = 6; i < 8; i++) begin
      step(1'b1, 8'hB5, 3'(i));
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, zero} !== {1'b1, 8'hB5, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reserved_op%0d: got v=%b r=%h c=%b z=%b want v=1 r=b5 c=0 z=0",
                 i, out_valid, result, carry, zero);
      end
    end
  endtask

  task automatic test_corners;
    exp_t e;
    logic [7:0] va   [5] = '{8'h80, 8'h01, 8'h81, 8'h81, 8'h81};
    logic [2:0] vop  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] wr   [5] = '{8'h00, 8'h00, 8'hC0, 8'h03, 8'hC0};
    logic       wz   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, va[i], vop[i]);
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, zero} !== {1'b1, wr[i], 1'b1, wz[i]}) begin
        n_err++;
        $display("FAIL corner%0d: got v=%b r=%h c=%b z=%b want v=1 r=%h c=1 z=%b",
                 i, out_valid, result, carry, zero, wr[i], wz[i]);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    step(1'b1, 8'h80, 3'd0);
    e = sb.pop_front();
    n_vec++;
    if ({out_valid, result, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL hold_load: got v=%b r=%h c=%b z=%b want v=1 r=00 c=1 z=1",
               out_valid, result, carry, zero);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 3'($urandom));
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, zero} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL hold_idle%0d: got v=%b r=%h c=%b z=%b want v=0 r=00 c=1 z=1",
                 i, out_valid, result, carry, zero);
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom));
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, zero} !== {e.v, e.r, e.c, e.z}) begin
        n_err++;
        $display("FAIL random%0d: got v=%b r=%h c=%b z=%b want v=%b r=%h c=%b z=%b",
                 i, out_valid, result, carry, zero, e.v, e.r, e.c, e.z);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_reserved();
    test_corners();
    test_hold();
    test_random();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
